// File: rtl/bcd_serial_sub.sv
// bcd_serial_sub: multi-digit BCD subtractor producing a sign-magnitude result.
// It handles one BCD digit per clock, starting with the least-significant digit.
// If the raw difference borrows out of the top digit, a second pass replaces
// diff with its ten's complement, which yields |a - b|.
//
// Ports:
//   clk     : system clock (rising edge)
//   rst     : synchronous active-high reset
//   start   : request, sampled only while idle
//   a, b    : packed BCD operands, digit 0 in bits [3:0]
//   busy    : high in every state except IDLE
//   done    : one-cycle pulse when diff/neg/invalid are valid
//   diff    : |a - b| as packed BCD
//   neg     : 1 when a < b
//   invalid : 1 when any input digit is greater than 9
module bcd_serial_sub #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4*NDIG-1:0] a,
  input  logic [4*NDIG-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] diff,
  output logic              neg,
  output logic              invalid
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SUB, S_NEG, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [4*NDIG-1:0] r_a, r_b, r_diff;
  logic [IW-1:0]     r_idx;
  logic              r_borrow, r_neg, r_invalid;

  logic              w_last, w_in_bad;
  logic [3:0]        w_ai, w_bi, w_di, w_x, w_y, w_dig;
  logic [4:0]        w_t;

  assign w_last = (r_idx == IW'(NDIG - 1));

  // Select the current digit of each register.
  always_comb begin
    w_ai = '0;
    w_bi = '0;
    w_di = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (r_idx == IW'(i)) begin
        w_ai = r_a[4*i +: 4];
        w_bi = r_b[4*i +: 4];
        w_di = r_diff[4*i +: 4];
      end
    end
  end

  always_comb begin
    w_in_bad = 1'b0;
    for (int i = 0; i < NDIG; i++)
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) w_in_bad = 1'b1;
  end

  // The SUB pass computes a_i - b_i. The NEG pass computes 0 - diff_i.
  // Both passes share one digit subtractor. Bit 4 of w_t is the sign,
  // which also serves as the borrow out.
  assign w_x   = (r_state == S_SUB) ? w_ai : 4'd0;
  assign w_y   = (r_state == S_SUB) ? w_bi : w_di;
  assign w_t   = {1'b0, w_x} - {1'b0, w_y} - {4'b0, r_borrow};
  assign w_dig = w_t[4] ? (w_t[3:0] + 4'd10) : w_t[3:0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = w_in_bad ? S_DONE : S_SUB;
      S_SUB:  if (w_last) w_next = w_t[4] ? S_NEG : S_DONE;
      S_NEG:  if (w_last) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_diff    <= '0;
      r_idx     <= '0;
      r_borrow  <= 1'b0;
      r_neg     <= 1'b0;
      r_invalid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a       <= a;
            r_b       <= b;
            r_diff    <= '0;
            r_neg     <= 1'b0;
            r_invalid <= w_in_bad;
            r_idx     <= '0;
            r_borrow  <= 1'b0;
          end
        end
        S_SUB, S_NEG: begin
          for (int i = 0; i < NDIG; i++)
            if (r_idx == IW'(i)) r_diff[4*i +: 4] <= w_dig;
          if (w_last) begin
            r_idx    <= '0;
            r_borrow <= 1'b0;
            // A borrow out of the top digit means a < b. The borrow is
            // nonzero only for a strict inequality, so negative zero cannot occur.
            if (r_state == S_SUB && w_t[4]) r_neg <= 1'b1;
          end else begin
            r_idx    <= r_idx + 1'b1;
            r_borrow <= w_t[4];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign diff    = r_diff;
  assign neg     = r_neg;
  assign invalid = r_invalid;

endmodule
